// File: rtl/amiq_i2c_ex_master_ctrl.sv
// Byte-level I2C master controller: one command per handshake (optional START, 8-bit
// write or read, ACK slot, optional STOP) driving open-drain SDA/SCL through pull-low enables.
module amiq_i2c_ex_master_ctrl #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_ack,
    output logic       rsp_arb_lost,
    input  logic       sda_i,
    input  logic       scl_i,
    output logic       sda_o,
    output logic       sda_o_en,
    output logic       scl_o,
    output logic       scl_o_en
);
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_BIT, ST_STOP, ST_DONE} state_t;

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    state_t     state_r, state_n;
    logic [7:0] phase_r, phase_n;
    logic [1:0] quarter_r, quarter_n;
    logic [3:0] slot_r, slot_n;
    logic       stop_r, read_r, nack_r, ack_r;
    logic [7:0] wdata_r, shift_r;
    logic       cmd_ready_r, rsp_valid_r, rsp_ack_r, rsp_arb_lost_r;
    logic [7:0] rsp_rdata_r;
    logic       sda_o_en_r, scl_o_en_r, sda_en_n, scl_en_n;
    logic       accept_s, stretch_s, arb_check_s, sample_s, ack_now_s, drive_bit_s;
    logic       cur_read_s, cur_nack_s;
    logic [7:0] cur_wdata_s;

    assign accept_s = cmd_valid && cmd_ready_r && (state_r == ST_IDLE);

    // The phase counter freezes while another device stretches SCL in the SCL-high quarters.
    assign stretch_s = !scl_i && (((state_r == ST_BIT) && quarter_r[1]) ||
                       (((state_r == ST_START) || (state_r == ST_STOP)) && (quarter_r == 2'd1)));

    assign arb_check_s = scl_i && !sda_i &&
                         (((state_r == ST_START) && (quarter_r == 2'd1)) ||
                          ((state_r == ST_BIT) && quarter_r[1] && !read_r && (slot_r != 4'd8) &&
                           wdata_r[~slot_r[2:0]]));

    assign sample_s  = (state_r == ST_BIT) && (quarter_r == 2'd3) && (phase_r == PHASE_LAST) &&
                       !stretch_s && !arb_check_s;
    assign ack_now_s = (sample_s && (slot_r == 4'd8)) ? ~sda_i : ack_r;

    // Fields are taken straight from the command port on the acceptance cycle.
    assign cur_read_s  = (state_r == ST_IDLE) ? cmd_read  : read_r;
    assign cur_nack_s  = (state_r == ST_IDLE) ? cmd_nack  : nack_r;
    assign cur_wdata_s = (state_r == ST_IDLE) ? cmd_wdata : wdata_r;

    // Next-state, quarter/phase sequencing and slot counting.
    always_comb begin
        state_n   = state_r;
        phase_n   = phase_r;
        quarter_n = quarter_r;
        slot_n    = slot_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n   = cmd_start ? ST_START : ST_BIT;
                    phase_n   = 8'd0;
                    quarter_n = 2'd0;
                    slot_n    = 4'd0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START, ST_BIT, ST_STOP: begin
                if (arb_check_s) begin
                    state_n = ST_DONE;
                end else if (stretch_s) begin
                    phase_n = phase_r;
                end else if (phase_r != PHASE_LAST) begin
                    phase_n = phase_r + 8'd1;
                end else begin
                    phase_n   = 8'd0;
                    quarter_n = quarter_r + 2'd1;
                    if (quarter_r != 2'd3) begin
                        state_n = state_r;
                    end else if (state_r == ST_START) begin
                        state_n = ST_BIT;
                        slot_n  = 4'd0;
                    end else if (state_r == ST_STOP) begin
                        state_n = ST_DONE;
                    end else if (slot_r != 4'd8) begin
                        slot_n = slot_r + 4'd1;
                    end else begin
                        state_n = stop_r ? ST_STOP : ST_DONE;
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Line enables decoded from the upcoming step so they change with the step boundary.
    always_comb begin
        sda_en_n = sda_o_en_r;
        scl_en_n = scl_o_en_r;
        if (slot_n == 4'd8) begin
            drive_bit_s = cur_read_s ? ~cur_nack_s : 1'b0;
        end else begin
            drive_bit_s = cur_read_s ? 1'b0 : ~cur_wdata_s[~slot_n[2:0]];
        end
        case (state_n)
            ST_START: begin
                case (quarter_n)
                    2'd0:    begin sda_en_n = 1'b0; scl_en_n = scl_o_en_r; end
                    2'd1:    begin sda_en_n = 1'b0; scl_en_n = 1'b0;       end
                    2'd2:    begin sda_en_n = 1'b1; scl_en_n = 1'b0;       end
                    default: begin sda_en_n = 1'b1; scl_en_n = 1'b1;       end
                endcase
            end
            ST_BIT: begin
                sda_en_n = drive_bit_s;
                scl_en_n = ~quarter_n[1];
            end
            ST_STOP: begin
                case (quarter_n)
                    2'd0:    begin sda_en_n = 1'b1; scl_en_n = 1'b1; end
                    2'd1:    begin sda_en_n = 1'b1; scl_en_n = 1'b0; end
                    default: begin sda_en_n = 1'b0; scl_en_n = 1'b0; end
                endcase
            end
            ST_DONE: begin
                // Without STOP the bus stays owned (SCL low); after arbitration loss it is freed.
                sda_en_n = 1'b0;
                scl_en_n = (state_r == ST_BIT) && !arb_check_s;
            end
            default: begin
                sda_en_n = sda_o_en_r;
                scl_en_n = scl_o_en_r;
            end
        endcase
    end

    // State, command latch, receive shifter, response and bus-enable registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            phase_r        <= 8'd0;
            quarter_r      <= 2'd0;
            slot_r         <= 4'd0;
            stop_r         <= 1'b0;
            read_r         <= 1'b0;
            nack_r         <= 1'b0;
            wdata_r        <= 8'h00;
            shift_r        <= 8'h00;
            ack_r          <= 1'b0;
            cmd_ready_r    <= 1'b1;
            rsp_valid_r    <= 1'b0;
            rsp_rdata_r    <= 8'h00;
            rsp_ack_r      <= 1'b0;
            rsp_arb_lost_r <= 1'b0;
            sda_o_en_r     <= 1'b0;
            scl_o_en_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            phase_r    <= phase_n;
            quarter_r  <= quarter_n;
            slot_r     <= slot_n;
            sda_o_en_r <= sda_en_n;
            scl_o_en_r <= scl_en_n;
            if (accept_s) begin
                stop_r  <= cmd_stop;
                read_r  <= cmd_read;
                nack_r  <= cmd_nack;
                wdata_r <= cmd_wdata;
                shift_r <= 8'h00;
                ack_r   <= 1'b0;
            end else if (sample_s) begin
                if (slot_r == 4'd8) begin
                    ack_r <= ~sda_i;
                end else begin
                    shift_r <= {shift_r[6:0], sda_i};
                end
            end
            rsp_valid_r <= (state_n == ST_DONE);
            if (state_n == ST_DONE) begin
                rsp_rdata_r    <= (read_r && !arb_check_s) ? shift_r : 8'h00;
                rsp_ack_r      <= arb_check_s ? 1'b0 : (read_r ? ~nack_r : ack_now_s);
                rsp_arb_lost_r <= arb_check_s;
            end
            if (accept_s) begin
                cmd_ready_r <= 1'b0;
            end else if (state_r == ST_DONE) begin
                cmd_ready_r <= 1'b1;
            end
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_rdata    = rsp_rdata_r;
    assign rsp_ack      = rsp_ack_r;
    assign rsp_arb_lost = rsp_arb_lost_r;
    assign sda_o        = 1'b0;
    assign scl_o        = 1'b0;
    assign sda_o_en     = sda_o_en_r;
    assign scl_o_en     = scl_o_en_r;

endmodule
